sys_input_stager: RTL
=====================

Name: sys_input_stager

Overview:
- Upstream feeder for the systolic array.
- Buffers a batch of input vectors (one element per array row) arriving over a valid/ready handshake, then replays them with a diagonal skew. Lane i is delayed i cycles, matching the array's one-cycle-per-PE valid propagation.
- Drives the array's data-in lanes, start/valid input and weight-switch input. Signals completion so the controller can issue the next batch.

Parameters:
- LANES, 2, number of array rows fed; lane i drives sys_data_in row i+1.
- DEPTH, 8, maximum vectors buffered per batch (power of 2, ≥2).
- DATA_W, 16, element width in bits (fixed-point, passed through unmodified).

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  stager can accept a vector.
- in_data  in  LANES*DATA_W  vector; lane i at bits [i*DATA_W +: DATA_W].
- go  in  1  close batch and start streaming.
- go_switch  in  1  sampled with go; request a weight switch pulse before data.
- busy  out  1  high from accepted go until done.
- count  out  $clog2(DEPTH)+1  vectors currently buffered.
- out_data  out  LANES*DATA_W  skewed lane data to array.
- out_start  out  1  lane-0 valid (to sys_start).
- out_switch  out  1  one-cycle weight switch pulse (to sys_switch_in).
- done  out  1  one-cycle pulse, batch fully presented.

Behaviour:
- Reset (rst=0, async): state IDLE; count=0; in_ready=0 while in reset, 1 in the first cycle after release; busy=0; out_data=0; out_start=0; out_switch=0; done=0. All skew registers are cleared.
- States: IDLE, LOAD, SWITCH, STREAM, DRAIN.
- IDLE/LOAD:
  - in_ready = (count<DEPTH). A handshake (in_valid&in_ready) writes the vector at the write pointer and increments count. The first write moves IDLE→LOAD.
  - go is accepted only when the post-edge count>0. A vector handshaken in the same cycle as go belongs to the batch.
  - go while count=0 and no simultaneous write: ignored, no done.
  - On accepted go, in_ready drops next cycle. Next state is SWITCH if go_switch=1, else STREAM.
- Full: count=DEPTH forces in_ready=0; in_valid is held off and no overwrite occurs.
- SWITCH: out_switch=1 for exactly one cycle, then STREAM.
- STREAM:
  - Reads one vector per cycle, oldest first, for count cycles.
  - Lane 0 is presented the cycle after the read decision; out_start=1 in each cycle lane 0 carries valid data.
  - Lane i element of vector k appears exactly i cycles after lane 0 of vector k.
- DRAIN: LANES-1 cycles flushing the skew registers, no new reads. When LANES=1, DRAIN is skipped.
- Latency (go at edge E0, no switch):
  - Lane 0 of vector 0 is valid in cycle E0+1.
  - Last lane of the last vector is valid in cycle E0+count+LANES-1.
  - done pulses in the cycle after that.
  - With switch, all of the above shift by +1; out_switch is in cycle E0+1.
- done cycle: state returns to IDLE; count=0 and pointers are reset; in_ready=1 the following cycle.
- Idle-lane values: out_data lanes not carrying valid data are 0 (zero psum contribution is harmless).
- Ignored inputs: go and go_switch are ignored while busy=1. in_valid is ignored while busy=1 (in_ready=0).
- Pointers wrap modulo DEPTH; count distinguishes full from empty.

Decomposition:
- Shared package tpu_pkg holds:
  - DATA_W default;
  - stager_state_t enum (IDLE, LOAD, SWITCH, STREAM, DRAIN);
  - a lane-slice helper function.
- One natural sub-module, skew_delay: a parameterised N-stage DATA_W shift register with async active-low clear. It is instantiated per lane with N=i; N=0 is a wire.
- Buffer storage is a flat register array inside sys_input_stager; no separate FIFO module.

Test Plan:
- Basic skew (LANES=2, DEPTH=4), no switch:
  - Stimulus: load (1,2),(3,4); go at E0.
  - Required response:
    - lane0 = 1 at E0+1, 3 at E0+2.
    - lane1 = 2 at E0+2, 4 at E0+3.
    - out_start high E0+1..E0+2.
    - done at E0+4, busy low after.
- Switch:
  - Stimulus: same load, go with go_switch=1.
  - Required response: out_switch only at E0+1; lane0=1 at E0+2; done at E0+5.
- Full/backpressure:
  - Stimulus: hold in_valid with vectors 10..14.
  - Required response: in_ready falls after 4 accepted; 14 is not written; count=4; stream order 10,11,12,13.
- Edge go:
  - go with count=0 → ignored, busy stays 0.
  - go in the same cycle as the first handshake of (7,8) → batch of 1; lane0=7 at E0+1, lane1=8 at E0+2.
- Reset mid-stream:
  - Stimulus: drop rst during STREAM.
  - Required response: all outputs are 0 immediately (asynchronously). After release, count=0 and in_ready=1; a fresh batch streams correctly.
- Back-to-back batches:
  - Stimulus: second batch loaded right after done.
  - Required response: second batch has no residual data from the first; lanes are 0 between batches.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic-array feeder blocks.
package tpu_pkg;

  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSwitch,
    StStream,
    StDrain
  } stager_state_t;

  // Low bit index of lane `lane` in a flat vector of `width`-bit elements.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_delay.sv
// N-stage shift register with async active-low clear; N=0 degenerates to a wire.
module skew_delay #(
  parameter int unsigned N      = 1,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  if (N == 0) begin : g_wire
    logic w_unused;
    assign w_unused = clk ^ rst;
    assign o_data   = i_data;
  end else begin : g_pipe
    logic [DATA_W-1:0] r_stage [N];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < int'(N); i++) r_stage[i] <= '0;
      end else begin
        r_stage[0] <= i_data;
        for (int i = 1; i < int'(N); i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[N-1];
  end

endmodule

// File: rtl/sys_input_stager.sv
// Buffers a batch of input vectors, then replays them into the systolic array with a
// per-lane diagonal skew (lane i delayed i cycles).
module sys_input_stager
  import tpu_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      go,
  input  logic                      go_switch,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    count,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_start,
  output logic                      out_switch,
  output logic                      done
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned DCW = (LANES > 1) ? $clog2(LANES) : 1;

  stager_state_t           r_state, w_state_nxt;
  logic [CW-1:0]           r_count, w_count_nxt;
  logic [PW-1:0]           r_wr_ptr, w_wr_ptr_nxt;
  logic [PW-1:0]           r_rd_ptr, w_rd_ptr_nxt;
  logic [DCW-1:0]          r_drain, w_drain_nxt;
  logic                    r_in_ready, w_in_ready_nxt;
  logic                    r_switch, w_switch_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_start;
  logic [LANES*DATA_W-1:0] r_lane0;
  logic [LANES*DATA_W-1:0] r_mem [DEPTH];
  logic                    w_wr, w_rd, w_finish;

  assign w_wr = in_valid & r_in_ready;
  assign w_rd = (r_state == StStream) && (r_count != '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_drain_nxt  = r_drain;
    w_switch_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_finish     = 1'b0;

    if (w_wr) begin
      w_count_nxt  = r_count + CW'(1);
      w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    end

    unique case (r_state)
      StIdle, StLoad: begin
        if (w_wr) w_state_nxt = StLoad;
        // A vector written alongside go joins the batch, so test the post-edge count.
        if (go && (w_count_nxt != '0)) w_state_nxt = go_switch ? StSwitch : StStream;
      end
      StSwitch: begin
        w_switch_nxt = 1'b1;
        w_state_nxt  = StStream;
      end
      StStream: begin
        if (w_rd) begin
          w_count_nxt  = r_count - CW'(1);
          w_rd_ptr_nxt = r_rd_ptr + PW'(1);
        end else if (LANES > 1) begin
          // Tail cycle: the last vector is sitting in the lane-0 register.
          w_state_nxt = StDrain;
          w_drain_nxt = '0;
        end else begin
          w_finish = 1'b1;
        end
      end
      StDrain: begin
        if (r_drain == DCW'(LANES - 2)) w_finish = 1'b1;
        else w_drain_nxt = r_drain + DCW'(1);
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_finish) begin
      w_state_nxt  = StIdle;
      w_done_nxt   = 1'b1;
      w_count_nxt  = '0;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end

    w_in_ready_nxt = ((w_state_nxt == StIdle) || (w_state_nxt == StLoad)) && !w_finish &&
                     (w_count_nxt < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drain    <= '0;
      r_in_ready <= 1'b0;
      r_switch   <= 1'b0;
      r_done     <= 1'b0;
      r_start    <= 1'b0;
      r_lane0    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_drain    <= w_drain_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_switch   <= w_switch_nxt;
      r_done     <= w_done_nxt;
      r_start    <= w_rd;
      r_lane0    <= w_rd ? r_mem[r_rd_ptr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_data;
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    skew_delay #(
      .N      (g),
      .DATA_W (DATA_W)
    ) u_skew (
      .clk    (clk),
      .rst    (rst),
      .i_data (r_lane0[lane_lo(g, DATA_W) +: DATA_W]),
      .o_data (out_data[lane_lo(g, DATA_W) +: DATA_W])
    );
  end

  assign in_ready   = r_in_ready;
  assign busy       = (r_state == StSwitch) || (r_state == StStream) || (r_state == StDrain);
  assign count      = r_count;
  assign out_start  = r_start;
  assign out_switch = r_switch;
  assign done       = r_done;

endmodule
